// File: rtl/disp_strict.sv
// Strict-priority dispatcher: one valid/ready stream fanned out whole-packet to the
// lowest-index enabled, ready consumer. Define DISP_STRICT_CNT_EN for per-consumer packet counters.
module disp_strict #(
   parameter int WID     = 4,
   parameter int DAT_WID = 32,
   parameter int CNT_WID = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_vld,
   input  logic [DAT_WID-1:0]     in_dat,
   input  logic                   in_lst,
   output logic                   in_rdy,
   input  logic [WID-1:0]         dst_en,
   output logic [WID-1:0]         out_vld,
   output logic [DAT_WID-1:0]     out_dat,
   output logic                   out_lst,
   input  logic [WID-1:0]         out_rdy
`ifdef DISP_STRICT_CNT_EN
   ,
   output logic [WID*CNT_WID-1:0] pkt_cnt
`endif
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t             state;
   logic               obuf_vld;
   logic [DAT_WID-1:0] obuf_dat;
   logic               obuf_lst;
   logic [WID-1:0]     obuf_dst;
   logic [WID-1:0]     lock_dst;

   logic [WID-1:0]     elig;
   logic [WID-1:0]     cand;
   logic               cand_ok;
   logic               fire_out;
   logic               fire_in;

   // Isolating the lowest set bit gives the strict-priority winner directly.
   assign elig    = out_rdy & dst_en;
   assign cand    = elig & (~elig + WID'(1));
   assign cand_ok = |elig;

   assign fire_out = obuf_vld & (|(obuf_dst & out_rdy));
   assign in_rdy   = ~rst & (~obuf_vld | fire_out) & ((state == LOCK) | cand_ok);
   assign fire_in  = in_vld & in_rdy;

   assign out_vld = obuf_dst & {WID{obuf_vld}};
   assign out_dat = obuf_dat;
   assign out_lst = obuf_lst;

   // A loading beat takes priority over draining, so drain and refill share one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         obuf_vld <= 1'b0;
         obuf_dat <= '0;
         obuf_lst <= 1'b0;
         obuf_dst <= '0;
         lock_dst <= '0;
      end else if (fire_in) begin
         obuf_vld <= 1'b1;
         obuf_dat <= in_dat;
         obuf_lst <= in_lst;
         if (state == IDLE) begin
            obuf_dst <= cand;
            if (!in_lst) begin
               lock_dst <= cand;
               state    <= LOCK;
            end
         end else begin
            obuf_dst <= lock_dst;
            if (in_lst) begin
               state <= IDLE;
            end
         end
      end else if (fire_out) begin
         obuf_vld <= 1'b0;
      end
   end

`ifdef DISP_STRICT_CNT_EN
   // A packet is counted when its last beat leaves the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pkt_cnt <= '0;
      end else if (fire_out && obuf_lst) begin
         for (int i = 0; i < WID; i++) begin
            if (obuf_dst[i]) begin
               pkt_cnt[i*CNT_WID +: CNT_WID] <= pkt_cnt[i*CNT_WID +: CNT_WID] + CNT_WID'(1);
            end
         end
      end
   end
`else
   // Counter width only matters when counters are built; keep it referenced.
   if (CNT_WID < 1) begin : g_cnt_wid_unused
   end
`endif

endmodule

// File: tb/tb_disp_strict.sv
// Self-checking bench for disp_strict: scoreboard of expected beats plus per-scenario tasks.
// Counter scenario is built only when DISP_STRICT_CNT_EN is defined.
module tb_disp_strict;

   localparam int WID     = 4;
   localparam int DAT_WID = 32;
   localparam int CNT_WID = 2;

   typedef logic [WID+DAT_WID:0] beat_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               in_vld = 1'b0;
   logic [DAT_WID-1:0] in_dat = '0;
   logic               in_lst = 1'b0;
   logic               in_rdy;
   logic [WID-1:0]     dst_en = '1;
   logic [WID-1:0]     out_vld;
   logic [DAT_WID-1:0] out_dat;
   logic               out_lst;
   logic [WID-1:0]     out_rdy = '1;
`ifdef DISP_STRICT_CNT_EN
   logic [WID*CNT_WID-1:0] pkt_cnt;
`endif

   beat_t          sb[$];
   logic [WID-1:0] exp_dst = '0;
   int             checks = 0;
   int             errors = 0;

   disp_strict #(.WID(WID), .DAT_WID(DAT_WID), .CNT_WID(CNT_WID)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_dat  (in_dat),
      .in_lst  (in_lst),
      .in_rdy  (in_rdy),
      .dst_en  (dst_en),
      .out_vld (out_vld),
      .out_dat (out_dat),
      .out_lst (out_lst),
      .out_rdy (out_rdy)
`ifdef DISP_STRICT_CNT_EN
      ,
      .pkt_cnt (pkt_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Every beat a consumer takes must be the oldest expected one, to the expected consumer.
   always @(negedge clk) begin
      beat_t exp_b;
      if (!rst && (|(out_vld & out_rdy))) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL sb_unexpected: got vld=%b dat=%h lst=%b, want no beat", out_vld, out_dat, out_lst);
         end else begin
            exp_b = sb.pop_front();
            if ({out_vld, out_dat, out_lst} !== exp_b) begin
               errors++;
               $display("[TB] FAIL sb_beat: got vld=%b dat=%h lst=%b, want vld=%b dat=%h lst=%b",
                        out_vld, out_dat, out_lst, exp_b[WID+DAT_WID:DAT_WID+1], exp_b[DAT_WID:1], exp_b[0]);
            end
         end
      end
   end

   // Called at the falling edge: record an accepted beat, then move to just after the next rising edge.
   task automatic tick();
      if (in_vld && in_rdy) sb.push_back({exp_dst, in_dat, in_lst});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      in_vld = 1'b1; in_dat = 32'hDEAD; in_lst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdy: got %b want 0", in_rdy); end
      checks++;
      if ({out_vld, out_dat, out_lst} !== '0) begin
         errors++; $display("[TB] FAIL reset_out: got vld=%b dat=%h lst=%b want all 0", out_vld, out_dat, out_lst);
      end
      in_vld = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      out_rdy = 4'b1110; dst_en = 4'hF; exp_dst = 4'b0010;
      in_vld = 1'b1; in_dat = 32'hA5; in_lst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_rdy: got %b want 1", in_rdy); end
      tick();
      in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0010 || out_dat !== 32'hA5 || out_lst !== 1'b1) begin
         errors++; $display("[TB] FAIL single_out: got vld=%b dat=%h lst=%b want 0010/a5/1", out_vld, out_dat, out_lst);
      end
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_rdy2: got %b want 1", in_rdy); end
      tick();
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0000) begin errors++; $display("[TB] FAIL single_drain: got %b want 0000", out_vld); end
      tick();
   endtask

   task automatic test_lock();
      out_rdy = 4'b0101; dst_en = 4'hF; exp_dst = 4'b0001;
      in_vld = 1'b1; in_dat = 32'h1; in_lst = 1'b0;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL lock_b1_rdy: got %b want 1", in_rdy); end
      tick();
      out_rdy = 4'b0100; in_dat = 32'h2;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_rdy !== 1'b0 || out_vld !== 4'b0001) begin
            errors++; $display("[TB] FAIL lock_stall: got rdy=%b vld=%b want 0/0001", in_rdy, out_vld);
         end
         tick();
      end
      out_rdy = 4'b0001;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL lock_b2_rdy: got %b want 1", in_rdy); end
      tick();
      // Consumer 0 disabled and consumer 2 ready: a re-arbitration would pick consumer 2.
      in_dat = 32'h3; in_lst = 1'b1; dst_en = 4'b1110; out_rdy = 4'b0101;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1 || out_vld !== 4'b0001) begin
         errors++; $display("[TB] FAIL lock_b3_rdy: got rdy=%b vld=%b want 1/0001", in_rdy, out_vld);
      end
      tick();
      in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0001 || out_lst !== 1'b1) begin
         errors++; $display("[TB] FAIL lock_last: got vld=%b lst=%b want 0001/1", out_vld, out_lst);
      end
      tick();
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0000) begin errors++; $display("[TB] FAIL lock_drain: got %b want 0000", out_vld); end
      tick();
      dst_en = 4'hF;
   endtask

   task automatic test_no_eligible();
      dst_en = 4'b1000; out_rdy = 4'b0111; exp_dst = 4'b1000;
      in_vld = 1'b1; in_dat = 32'h77; in_lst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (in_rdy !== 1'b0 || out_vld !== 4'b0000) begin
            errors++; $display("[TB] FAIL noelig_block: got rdy=%b vld=%b want 0/0000", in_rdy, out_vld);
         end
         tick();
      end
      out_rdy = 4'b1111;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL noelig_rdy: got %b want 1", in_rdy); end
      tick();
      in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b1000) begin errors++; $display("[TB] FAIL noelig_out: got %b want 1000", out_vld); end
      tick();
      dst_en = 4'hF;
   endtask

   task automatic test_back_to_back();
      out_rdy = 4'hF; dst_en = 4'hF; exp_dst = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         in_vld = 1'b1; in_dat = 32'h100 + i; in_lst = 1'b1;
         @(negedge clk);
         checks++;
         if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_rdy: beat %0d got %b want 1", i, in_rdy); end
         if (i > 0) begin
            checks++;
            if (out_vld !== 4'b0001 || out_dat !== 32'h100 + i - 1) begin
               errors++; $display("[TB] FAIL b2b_out: got vld=%b dat=%h want 0001/%h", out_vld, out_dat, 32'h100 + i - 1);
            end
         end
         tick();
      end
      in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0001 || out_dat !== 32'h107) begin
         errors++; $display("[TB] FAIL b2b_tail: got vld=%b dat=%h want 0001/107", out_vld, out_dat);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      out_rdy = 4'hF; dst_en = 4'hF; exp_dst = 4'b0001;
      in_vld = 1'b1; in_lst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_dat = 32'h200 + i;
         @(negedge clk);
         tick();
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_vld !== 4'b0000 || in_rdy !== 1'b0) begin
         errors++; $display("[TB] FAIL rstmid_async: got vld=%b rdy=%b want 0000/0", out_vld, in_rdy);
      end
      sb.delete();
      in_vld = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      out_rdy = 4'b0100; exp_dst = 4'b0100;
      in_vld = 1'b1; in_dat = 32'h55; in_lst = 1'b1;
      @(negedge clk);
      checks++;
      if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_rdy: got %b want 1", in_rdy); end
      tick();
      in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (out_vld !== 4'b0100 || out_lst !== 1'b1) begin
         errors++; $display("[TB] FAIL rstmid_out: got vld=%b lst=%b want 0100/1", out_vld, out_lst);
      end
      tick();
   endtask

`ifdef DISP_STRICT_CNT_EN
   task automatic test_counter();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      out_rdy = 4'b0100; dst_en = 4'hF; exp_dst = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         in_vld = 1'b1; in_dat = 32'h300 + i; in_lst = 1'b1;
         @(negedge clk);
         tick();
      end
      in_vld = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tick();
      end
      @(negedge clk);
      checks++;
      if (pkt_cnt !== 8'b00_01_00_00) begin
         errors++; $display("[TB] FAIL cnt_wrap: got %b want 00010000", pkt_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_lock();
      test_no_eligible();
      test_back_to_back();
      test_reset_mid();
`ifdef DISP_STRICT_CNT_EN
      test_counter();
`endif
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin errors++; $display("[TB] FAIL sb_empty: got %0d pending want 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/disp_strict.md
Name: disp_strict

Overview:
- Strict-priority dispatcher: one upstream valid/ready stream fanned out to WID downstream consumers. It is the demux counterpart of the strict-priority arbiter.
- Each packet goes whole to one consumer. That consumer is the lowest-index one that is enabled and ready when the packet's first beat is accepted.
- A single registered output stage gives 1-cycle latency at full throughput.
- Sits between a shared producer (e.g. a DMA read engine) and a bank of identical workers.

Parameters:
- WID, 4, number of downstream consumers (>=2).
- DAT_WID, 32, data bus width in bits.
- CNT_WID, 16, per-consumer packet counter width (used only with DISP_STRICT_CNT_EN).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_vld  input  1  upstream beat valid.
- in_dat  input  DAT_WID  upstream beat data.
- in_lst  input  1  last beat of packet.
- in_rdy  output  1  upstream ready.
- dst_en  input  WID  consumer enable mask; bit i=1 means consumer i is eligible for new packets.
- out_vld  output  WID  per-consumer valid, one-hot or zero.
- out_dat  output  DAT_WID  data, broadcast to all consumers.
- out_lst  output  1  last flag, broadcast.
- out_rdy  input  WID  per-consumer ready.
- pkt_cnt  output  WID*CNT_WID  completed-packet counts; consumer i in bits [i*CNT_WID +: CNT_WID]. Present only with DISP_STRICT_CNT_EN.

Behaviour:
- Clocking/reset:
  - Single clock clk, rising edge.
  - rst is asynchronous, active-high, and clears all state.
  - Reset values: in_rdy=0 while rst is asserted; out_vld=0, out_dat=0, out_lst=0, pkt_cnt=0; state=IDLE; obuf_vld=0; lock_dst=0.
- Output buffer:
  - Holds one beat: obuf_vld, obuf_dat, obuf_lst, obuf_dst (WID one-hot).
  - out_vld = obuf_dst & {WID{obuf_vld}}; out_dat=obuf_dat; out_lst=obuf_lst.
  - fire_out = obuf_vld & |(obuf_dst & out_rdy).
- Candidate: cand = lowest-index set bit of (out_rdy & dst_en), one-hot; cand_ok = |(out_rdy & dst_en).
- Upstream ready:
  - in_rdy = ~rst & (~obuf_vld | fire_out) & (state==LOCK | cand_ok).
  - fire_in = in_vld & in_rdy.
- State machine, IDLE / LOCK:
  - IDLE, fire_in & in_lst: load obuf with dest=cand; stay IDLE (single-beat packet).
  - IDLE, fire_in & ~in_lst: load obuf with dest=cand; lock_dst<=cand; go LOCK.
  - LOCK, fire_in: load obuf with dest=lock_dst. If in_lst, go IDLE.
  - LOCK: out_rdy and dst_en are ignored for selection. Deasserting dst_en[lock_dst] mid-packet does not break the packet.
- Buffer update:
  - fire_in loads obuf and sets obuf_vld=1.
  - Else fire_out clears obuf_vld.
  - Simultaneous fire_out and fire_in: the old beat drains and the new beat loads in the same cycle, giving 1 beat/cycle.
- Latency: exactly 1 cycle from fire_in to out_vld.
- Holding rules:
  - out_dat, out_lst and out_vld stay stable while obuf_vld=1 and the target's out_rdy=0.
  - Upstream must hold in_vld/in_dat/in_lst until in_rdy.
- Boundaries:
  - dst_en=0 or no enabled consumer ready in IDLE: in_rdy=0; nothing is accepted.
  - All consumers ready: consumer 0 wins.
  - In IDLE, a new packet may be accepted while the previous packet's last beat is still buffered. The new destination can differ; ordering is preserved because there is a single buffer.
  - rst mid-packet: the partial packet is discarded. Consumers may see a truncated packet with no out_lst; the system resets them jointly.

Optional Feature:
- Macro: DISP_STRICT_CNT_EN.
- Defined:
  - pkt_cnt port exists.
  - Counter i increments by 1 when fire_out & obuf_lst & obuf_dst[i].
  - Wraps from 2^CNT_WID-1 to 0.
  - Cleared by rst.
- Undefined: pkt_cnt port and counters are absent; no other behaviour changes.

Test Plan:
- Single beat, consumer 1 chosen: out_rdy=4'b1110, dst_en=4'hF, in beat 0xA5 with in_lst=1 -> next cycle out_vld=4'b0010, out_dat=0xA5, out_lst=1; drains same cycle; in_rdy=1 throughout.
- Lock across packet: 3-beat packet 0x1,0x2,0x3 starts with out_rdy=4'b0101 (consumer 0 chosen); out_rdy changes to 4'b0100 after beat 1 -> beats 2,3 still go to consumer 0 only; in_rdy=0 until out_rdy[0]=1; no beat goes to consumer 2.
- No eligible consumer: dst_en=4'b1000, out_rdy=4'b0111, in_vld=1 -> in_rdy=0 and out_vld=0 for 10 cycles; setting out_rdy[3]=1 -> beat accepted, out_vld=4'b1000 next cycle.
- Back-to-back throughput: 8 single-beat packets, all out_rdy=1 -> in_rdy=1 every cycle, all delivered to consumer 0, consecutive cycles, order preserved.
- Reset mid-packet: assert rst after beat 2 of 4 -> out_vld=0 and in_rdy=0 immediately (asynchronous); after release, state=IDLE and next packet re-arbitrates from cand.
- DISP_STRICT_CNT_EN, CNT_WID=2: 5 single-beat packets to consumer 2 -> pkt_cnt[2]=1 (wrapped); other counters 0.
